// File: rtl/sint_limb_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : sint_limb_adder_seq
// Brief    : Serial LIMBS x WIDTH signed adder, one add-with-carry limb per cycle.
//            Optional: define SINT_LIMB_ADDER_STICKY_OVF_EN for OVF_STICKY.
// Revision : 1.0 - initial release
// ============================================================================
module sint_limb_adder_seq #(
    parameter int WIDTH = 7,
    parameter int LIMBS = 4
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*LIMBS-1:0]   I0,
    input  logic [WIDTH*LIMBS-1:0]   I1,
    input  logic                     CIN,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*LIMBS-1:0]   O,
    output logic                     COUT,
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
    output logic                     OVF_STICKY,
`endif
    output logic                     OVF
);

    localparam int N  = WIDTH * LIMBS;
    localparam int KW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [KW-1:0] c_last_k = KW'(LIMBS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_o;
    logic [KW-1:0]    r_k;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic             w_last;
    logic [WIDTH:0]   w_usum;
    logic [WIDTH:0]   w_ssum;
    logic [WIDTH-1:0] w_limb_sum;
    logic [N-1:0]     w_o_next;

    // Operands are shifted down each RUN cycle, so the active limb is always the LSBs.
    assign w_last = (r_k == c_last_k);
    assign w_usum = {1'b0, r_a[WIDTH-1:0]} + {1'b0, r_b[WIDTH-1:0]}
                  + {{WIDTH{1'b0}}, r_carry};
    assign w_ssum = {r_a[WIDTH-1], r_a[WIDTH-1:0]} + {r_b[WIDTH-1], r_b[WIDTH-1:0]}
                  + {{WIDTH{1'b0}}, r_carry};
    assign w_limb_sum = w_last ? w_ssum[WIDTH-1:0] : w_usum[WIDTH-1:0];

    always_comb begin
        w_o_next = r_o;
        for (int i = 0; i < LIMBS; i++) begin
            if (r_k == KW'(i)) begin
                w_o_next[i*WIDTH +: WIDTH] = w_limb_sum;
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_a     <= '0;
            r_b     <= '0;
            r_o     <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= I0;
                        r_b     <= I1;
                        r_carry <= CIN;
                        r_k     <= '0;
                    end
                end
                S_RUN: begin
                    r_o <= w_o_next;
                    r_a <= r_a >> WIDTH;
                    r_b <= r_b >> WIDTH;
                    if (w_last) begin
                        r_cout <= w_ssum[WIDTH];
                        r_ovf  <= w_ssum[WIDTH] ^ w_ssum[WIDTH-1];
                    end else begin
                        r_carry <= w_usum[WIDTH];
                        r_k     <= r_k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
    logic r_ovf_sticky;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_ovf_sticky <= 1'b0;
        end else if ((r_state == S_DONE) && out_ready && r_ovf) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign OVF_STICKY = r_ovf_sticky;
`endif

    assign O    = r_o;
    assign COUT = r_cout;
    assign OVF  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sint_limb_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sint_limb_adder_seq
// Brief    : Directed bench for sint_limb_adder_seq (LIMBS=1 and LIMBS=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sint_limb_adder_seq;

    logic CLK = 1'b0;
    logic ASYNCRESETN = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // LIMBS=4 instance
    logic        in_valid4 = 1'b0;
    logic        in_ready4;
    logic [27:0] a4 = '0;
    logic [27:0] b4 = '0;
    logic        cin4 = 1'b0;
    logic        out_valid4;
    logic        out_ready4 = 1'b0;
    logic [27:0] o4;
    logic        cout4;
    logic        ovf4;
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
    logic        sticky4;
    logic        sticky1;
`endif

    // LIMBS=1 instance
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [6:0]  a1 = '0;
    logic [6:0]  b1 = '0;
    logic        cin1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [6:0]  o1;
    logic        cout1;
    logic        ovf1;

    sint_limb_adder_seq #(.WIDTH(7), .LIMBS(4)) u_d4 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .I0(a4), .I1(b4), .CIN(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .O(o4), .COUT(cout4),
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
        .OVF_STICKY(sticky4),
`endif
        .OVF(ovf4)
    );

    sint_limb_adder_seq #(.WIDTH(7), .LIMBS(1)) u_d1 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .I0(a1), .I1(b1), .CIN(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .O(o1), .COUT(cout1),
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
        .OVF_STICKY(sticky1),
`endif
        .OVF(ovf1)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Caller is at posedge+1 with the 4-limb DUT idle; returns at posedge+1 after the handshake.
    task automatic do_op4(input string tag, input logic [27:0] a, input logic [27:0] b,
                          input logic c, input logic [27:0] eo, input logic ec, input logic ev);
        int cnt;
        check_val({tag, "_in_ready"}, in_ready4, 1);
        in_valid4 = 1'b1; a4 = a; b4 = b; cin4 = c;
        @(posedge CLK); #1;
        in_valid4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~c;
        cnt = 0;
        while (!out_valid4 && cnt < 20) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check_val({tag, "_latency"}, cnt, 4);
        check_val({tag, "_o"}, o4, eo);
        check_val({tag, "_cout"}, cout4, ec);
        check_val({tag, "_ovf"}, ovf4, ev);
        out_ready4 = 1'b1;
        @(posedge CLK); #1;
        out_ready4 = 1'b0;
        check_val({tag, "_out_valid_clr"}, out_valid4, 0);
    endtask

    initial begin
        int cnt;
        #2;
        check_val("rst_in_ready", in_ready4, 1);
        check_val("rst_out_valid", out_valid4, 0);
        check_val("rst_o", o4, 0);
        check_val("rst_cout", cout4, 0);
        check_val("rst_ovf", ovf4, 0);
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
        check_val("rst_sticky", sticky4, 0);
`endif
        repeat (2) @(posedge CLK);
        #1 ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;

        // LIMBS=1: 0x3F + 0x01 -> 0x40 with signed overflow
        in_valid1 = 1'b1; a1 = 7'h3F; b1 = 7'h01; cin1 = 1'b0;
        @(posedge CLK); #1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0;
        cnt = 0;
        while (!out_valid1 && cnt < 20) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check_val("l1_latency", cnt, 1);
        check_val("l1_o", o1, 7'h40);
        check_val("l1_cout", cout1, 0);
        check_val("l1_ovf", ovf1, 1);
        out_ready1 = 1'b1;
        @(posedge CLK); #1;
        out_ready1 = 1'b0;
        check_val("l1_in_ready", in_ready1, 1);

        do_op4("ripple", 28'h01FFFFF, 28'h0, 1'b1, 28'h0200000, 1'b0, 1'b0);
        do_op4("neg_neg", 28'hFFFFFFF, 28'hFFFFFFF, 1'b0, 28'hFFFFFFE, 1'b1, 1'b0);
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
        check_val("sticky_before", sticky4, 0);
`endif
        do_op4("pos_ovf", 28'h7FFFFFF, 28'h0000001, 1'b0, 28'h8000000, 1'b0, 1'b1);
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
        check_val("sticky_set", sticky4, 1);
`endif
        do_op4("small", 28'h0000005, 28'h0000003, 1'b0, 28'h0000008, 1'b0, 1'b0);
`ifdef SINT_LIMB_ADDER_STICKY_OVF_EN
        check_val("sticky_hold", sticky4, 1);
`endif
        do_op4("neg_ovf", 28'h8000000, 28'hFFFFFFF, 1'b0, 28'h7FFFFFF, 1'b1, 1'b1);

        // Backpressure: result held, new operands refused
        in_valid4 = 1'b1; a4 = 28'h1234567; b4 = 28'h0000001; cin4 = 1'b1;
        @(posedge CLK); #1;
        a4 = 28'h0AAAAAA; b4 = 28'h0555555; cin4 = 1'b0;
        cnt = 0;
        while (!out_valid4 && cnt < 20) begin
            @(posedge CLK); #1;
            cnt++;
        end
        check_val("bp_latency", cnt, 4);
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_valid", out_valid4, 1);
            check_val("bp_in_ready", in_ready4, 0);
            check_val("bp_o", o4, 28'h1234569);
            check_val("bp_cout", cout4, 0);
            check_val("bp_ovf", ovf4, 0);
            @(posedge CLK); #1;
        end
        out_ready4 = 1'b1;
        @(posedge CLK); #1;
        out_ready4 = 1'b0; in_valid4 = 1'b0;
        check_val("bp_release_in_ready", in_ready4, 1);
        check_val("bp_release_out_valid", out_valid4, 0);
        do_op4("after_bp", 28'h0AAAAAA, 28'h0555555, 1'b0, 28'h0FFFFFF, 1'b0, 1'b0);

        // Reset while limb 2 is being added
        in_valid4 = 1'b1; a4 = 28'h1234567; b4 = 28'h1111111; cin4 = 1'b0;
        @(posedge CLK); #1;
        in_valid4 = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_val("mid_busy", in_ready4, 0);
        ASYNCRESETN = 1'b0;
        #1;
        check_val("mid_rst_out_valid", out_valid4, 0);
        check_val("mid_rst_o", o4, 0);
        check_val("mid_rst_in_ready", in_ready4, 1);
        @(posedge CLK); #1;
        ASYNCRESETN = 1'b1;
        @(posedge CLK); #1;
        check_val("post_rst_out_valid", out_valid4, 0);
        do_op4("post_rst", 28'h1234567, 28'h1111111, 1'b0, 28'h2345678, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
